// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-to-one IFU/LSU arbiter onto a single AXI4-subset master
//
// Latches single-cycle request pulses from the fetch (ifu_*) and load/store (lsu_*)
// ports into per-port pending registers and issues one bus transaction at a time.
// LSU has priority over IFU. A one-cycle response pulse with the read word returns
// to the port that owns the finished transaction.
//
// Ports:
//   clock, reset                      rising-edge clock, asynchronous active-high reset
//   ifu_reqValid/ifu_addr             fetch request pulse and word address
//   ifu_respValid/ifu_rdata           fetch response pulse and fetched word
//   lsu_reqValid/addr/size/wen/wdata/wmask   load/store request pulse and fields
//   lsu_respValid/lsu_rdata           completion pulse, raw bus word (0 for stores)
//   ar*/r*/aw*/w*/b*                  AXI4-subset master channels, all outputs registered
//   err_valid/err_addr                sticky first bus error and its address
//
// Optional feature: define MEM_ARB_ERR_EN to record the first non-OKAY rresp/bresp;
// otherwise err_valid/err_addr are tied to 0.

module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ifu_reqValid,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_respValid,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_reqValid,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [1:0]        lsu_size,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [3:0]        lsu_wmask,
    output logic              lsu_respValid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arsize,
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    output logic              awvalid,
    input  logic              awready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic              wvalid,
    input  logic              wready,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    input  logic              bvalid,
    output logic              bready,
    input  logic [1:0]        bresp,
    output logic              err_valid,
    output logic [ADDR_W-1:0] err_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RADDR,
        S_RDATA,
        S_WADDR,
        S_WRESP
    } state_t;

    state_t              state_q, state_d;
    logic                gnt_lsu_q, gnt_lsu_d;

    logic                ifu_pend_q, ifu_pend_d;
    logic [ADDR_W-1:0]   ifu_addr_q, ifu_addr_d;
    logic                lsu_pend_q, lsu_pend_d;
    logic [ADDR_W-1:0]   lsu_addr_q, lsu_addr_d;
    logic [1:0]          lsu_size_q, lsu_size_d;
    logic                lsu_wen_q, lsu_wen_d;
    logic [DATA_W-1:0]   lsu_wdata_q, lsu_wdata_d;
    logic [3:0]          lsu_wmask_q, lsu_wmask_d;

    logic                arvalid_q, arvalid_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic [2:0]          arsize_q, arsize_d;
    logic                rready_q, rready_d;
    logic                awvalid_q, awvalid_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [2:0]          awsize_q, awsize_d;
    logic                wvalid_q, wvalid_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic                bready_q, bready_d;

    logic                ifu_resp_q, ifu_resp_d;
    logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d;
    logic                lsu_resp_q, lsu_resp_d;
    logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;

    // AW and W complete independently; a channel already dropped counts as done.
    logic                aw_done, w_done;
    assign aw_done = !awvalid_q || awready;
    assign w_done  = !wvalid_q  || wready;

    always_comb begin
        state_d     = state_q;
        gnt_lsu_d   = gnt_lsu_q;
        ifu_pend_d  = ifu_pend_q;
        ifu_addr_d  = ifu_addr_q;
        lsu_pend_d  = lsu_pend_q;
        lsu_addr_d  = lsu_addr_q;
        lsu_size_d  = lsu_size_q;
        lsu_wen_d   = lsu_wen_q;
        lsu_wdata_d = lsu_wdata_q;
        lsu_wmask_d = lsu_wmask_q;
        arvalid_d   = arvalid_q;
        araddr_d    = araddr_q;
        arsize_d    = arsize_q;
        rready_d    = rready_q;
        awvalid_d   = awvalid_q;
        awaddr_d    = awaddr_q;
        awsize_d    = awsize_q;
        wvalid_d    = wvalid_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bready_d    = bready_q;
        ifu_resp_d  = 1'b0;
        ifu_rdata_d = ifu_rdata_q;
        lsu_resp_d  = 1'b0;
        lsu_rdata_d = lsu_rdata_q;

        // A pulse on an already-pending port is dropped. Capture and grant of the
        // same port never coincide: grant needs pend_q set, capture needs it clear.
        if (ifu_reqValid && !ifu_pend_q) begin
            ifu_pend_d = 1'b1;
            ifu_addr_d = ifu_addr;
        end
        if (lsu_reqValid && !lsu_pend_q) begin
            lsu_pend_d  = 1'b1;
            lsu_addr_d  = lsu_addr;
            lsu_size_d  = lsu_size;
            lsu_wen_d   = lsu_wen;
            lsu_wdata_d = lsu_wdata;
            lsu_wmask_d = lsu_wmask;
        end

        unique case (state_q)
            S_IDLE: begin
                if (lsu_pend_q) begin
                    lsu_pend_d = 1'b0;
                    gnt_lsu_d  = 1'b1;
                    if (lsu_wen_q) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = lsu_addr_q;
                        awsize_d  = {1'b0, lsu_size_q};
                        wdata_d   = lsu_wdata_q;
                        wstrb_d   = lsu_wmask_q;
                        state_d   = S_WADDR;
                    end else begin
                        arvalid_d = 1'b1;
                        araddr_d  = lsu_addr_q;
                        arsize_d  = {1'b0, lsu_size_q};
                        state_d   = S_RADDR;
                    end
                end else if (ifu_pend_q) begin
                    ifu_pend_d = 1'b0;
                    gnt_lsu_d  = 1'b0;
                    arvalid_d  = 1'b1;
                    araddr_d   = ifu_addr_q;
                    arsize_d   = 3'd2;
                    state_d    = S_RADDR;
                end
            end
            S_RADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RDATA;
                end
            end
            S_RDATA: begin
                if (rvalid) begin
                    rready_d = 1'b0;
                    state_d  = S_IDLE;
                    if (gnt_lsu_q) begin
                        lsu_resp_d  = 1'b1;
                        lsu_rdata_d = rdata;
                    end else begin
                        ifu_resp_d  = 1'b1;
                        ifu_rdata_d = rdata;
                    end
                end
            end
            S_WADDR: begin
                if (awready) awvalid_d = 1'b0;
                if (wready)  wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = S_WRESP;
                end
            end
            S_WRESP: begin
                if (bvalid) begin
                    bready_d    = 1'b0;
                    state_d     = S_IDLE;
                    lsu_resp_d  = 1'b1;
                    lsu_rdata_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            gnt_lsu_q   <= 1'b0;
            ifu_pend_q  <= 1'b0;
            ifu_addr_q  <= '0;
            lsu_pend_q  <= 1'b0;
            lsu_addr_q  <= '0;
            lsu_size_q  <= '0;
            lsu_wen_q   <= 1'b0;
            lsu_wdata_q <= '0;
            lsu_wmask_q <= '0;
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            arsize_q    <= '0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            awaddr_q    <= '0;
            awsize_q    <= '0;
            wvalid_q    <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bready_q    <= 1'b0;
            ifu_resp_q  <= 1'b0;
            ifu_rdata_q <= '0;
            lsu_resp_q  <= 1'b0;
            lsu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_lsu_q   <= gnt_lsu_d;
            ifu_pend_q  <= ifu_pend_d;
            ifu_addr_q  <= ifu_addr_d;
            lsu_pend_q  <= lsu_pend_d;
            lsu_addr_q  <= lsu_addr_d;
            lsu_size_q  <= lsu_size_d;
            lsu_wen_q   <= lsu_wen_d;
            lsu_wdata_q <= lsu_wdata_d;
            lsu_wmask_q <= lsu_wmask_d;
            arvalid_q   <= arvalid_d;
            araddr_q    <= araddr_d;
            arsize_q    <= arsize_d;
            rready_q    <= rready_d;
            awvalid_q   <= awvalid_d;
            awaddr_q    <= awaddr_d;
            awsize_q    <= awsize_d;
            wvalid_q    <= wvalid_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            bready_q    <= bready_d;
            ifu_resp_q  <= ifu_resp_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_resp_q  <= lsu_resp_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

    assign arvalid       = arvalid_q;
    assign araddr        = araddr_q;
    assign arsize        = arsize_q;
    assign rready        = rready_q;
    assign awvalid       = awvalid_q;
    assign awaddr        = awaddr_q;
    assign awsize        = awsize_q;
    assign wvalid        = wvalid_q;
    assign wdata         = wdata_q;
    assign wstrb         = wstrb_q;
    assign bready        = bready_q;
    assign ifu_respValid = ifu_resp_q;
    assign ifu_rdata     = ifu_rdata_q;
    assign lsu_respValid = lsu_resp_q;
    assign lsu_rdata     = lsu_rdata_q;

`ifdef MEM_ARB_ERR_EN
    logic              err_valid_q, err_valid_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    // Only the first error is kept; the address registers still hold the
    // faulting transaction's address during its R/B handshake.
    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        if (!err_valid_q) begin
            if (state_q == S_RDATA && rvalid && rresp != 2'b00) begin
                err_valid_d = 1'b1;
                err_addr_d  = araddr_q;
            end else if (state_q == S_WRESP && bvalid && bresp != 2'b00) begin
                err_valid_d = 1'b1;
                err_addr_d  = awaddr_q;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;
`else
    logic unused_err;
    assign unused_err = ^{rresp, bresp};
    assign err_valid  = 1'b0;
    assign err_addr   = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed self-checking bench for mem_arbiter

module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_reqValid;
    logic [31:0] ifu_addr;
    logic        ifu_respValid;
    logic [31:0] ifu_rdata;
    logic        lsu_reqValid;
    logic [31:0] lsu_addr;
    logic [1:0]  lsu_size;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_respValid;
    logic [31:0] lsu_rdata;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        err_valid;
    logic [31:0] err_addr;

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr),
        .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata),
        .lsu_reqValid(lsu_reqValid), .lsu_addr(lsu_addr), .lsu_size(lsu_size),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsize(arsize),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awsize(awsize),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .err_valid(err_valid), .err_addr(err_addr)
    );

`ifdef MEM_ARB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp_rdata;
    } lreq_t;

    // Outstanding requests per port (issued, response not yet seen) and stores
    // still expected on the write channels, all in issue order.
    logic [31:0] ifu_q[$];
    lreq_t       lsu_q[$];
    lreq_t       st_q[$];

    // Slave memory: word returned depends on address and transfer size.
    bit          fixed_en = 1'b0;
    logic [31:0] fixed_val = '0;
    function automatic logic [31:0] bus_word(input logic [31:0] a, input logic [2:0] s);
        if (fixed_en) return fixed_val;
        return {a[15:0], a[31:16]} ^ (32'h1 << s) ^ 32'hC0DE_0000;
    endfunction

    // Slave state and per-channel wait counts.
    int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [1:0] rresp_val = 2'b00, bresp_val = 2'b00;
    bit   ar_act, aw_act, w_act, rd_pend, aw_got, w_got, b_pend;
    int   ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    logic [31:0] rd_a, got_awaddr, got_wdata;
    logic [2:0]  rd_s, got_awsize;
    logic [3:0]  got_wstrb;

    // Outputs seen in the previous cycle, used to recognise handshakes.
    logic        p_arvalid, p_rready, p_awvalid, p_wvalid, p_bready;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [2:0]  p_arsize;

    int          cyc = 0;
    logic [31:0] ar_addr_log[$];
    int          ar_cyc_log[$];
    int          aw_hs_cyc, w_hs_cyc, ifu_resp_cyc, lsu_resp_cyc;
    int          ifu_resp_n = 0, lsu_resp_n = 0;
    logic [2:0]  last_arsize, last_awsize;
    logic [3:0]  last_wstrb;

    task automatic clear_bench();
        ifu_q.delete(); lsu_q.delete(); st_q.delete();
        ar_act = 0; aw_act = 0; w_act = 0; rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
        arready = 0; rvalid = 0; rdata = '0; rresp = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = '0;
        p_arvalid = 0; p_rready = 0; p_awvalid = 0; p_wvalid = 0; p_bready = 0;
        p_araddr = '0; p_awaddr = '0; p_wdata = '0; p_arsize = '0;
        ifu_reqValid = 0; ifu_addr = '0;
        lsu_reqValid = 0; lsu_addr = '0; lsu_size = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
    endtask

    task automatic issue_ifu(input logic [31:0] a);
        assert (ifu_q.size() == 0) else $error("ifu pulse while a fetch is outstanding");
        ifu_reqValid = 1'b1;
        ifu_addr     = a;
        ifu_q.push_back(bus_word(a, 3'd2));
    endtask

    task automatic issue_lsu(input logic wen, input logic [31:0] a, input logic [1:0] sz,
                             input logic [31:0] wd, input logic [3:0] wm);
        lreq_t r;
        assert (lsu_q.size() == 0) else $error("lsu pulse while an access is outstanding");
        r.wen = wen; r.addr = a; r.size = sz; r.wdata = wd; r.wmask = wm;
        r.exp_rdata = wen ? 32'h0 : bus_word(a, {1'b0, sz});
        lsu_q.push_back(r);
        if (wen) st_q.push_back(r);
        lsu_reqValid = 1'b1;
        lsu_addr = a; lsu_size = sz; lsu_wen = wen; lsu_wdata = wd; lsu_wmask = wm;
    endtask

    // One clock: observe what happened at the edge, score responses, then drive
    // the slave's inputs for the new cycle.
    task automatic step();
        bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
        lreq_t s;
        @(posedge clock);
        #1;
        cyc++;
        ifu_reqValid = 1'b0;
        lsu_reqValid = 1'b0;

        ar_hs = p_arvalid && arready;
        r_hs  = p_rready  && rvalid;
        aw_hs = p_awvalid && awready;
        w_hs  = p_wvalid  && wready;
        b_hs  = p_bready  && bvalid;

        if (p_arvalid && !ar_hs) check("arvalid_hold", {arvalid, araddr}, {1'b1, p_araddr});
        if (p_awvalid && !aw_hs) check("awvalid_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
        if (p_wvalid  && !w_hs)  check("wvalid_hold",  {wvalid, wdata},   {1'b1, p_wdata});

        if (ar_hs) begin
            ar_addr_log.push_back(p_araddr);
            ar_cyc_log.push_back(cyc - 1);
            last_arsize = p_arsize;
            rd_pend = 1; rd_a = p_araddr; rd_s = p_arsize; r_cnt = r_dly;
            ar_act = 0; arready = 0;
        end
        if (r_hs) begin rd_pend = 0; rvalid = 0; end
        if (aw_hs) begin
            aw_got = 1; got_awaddr = p_awaddr; got_awsize = awsize; aw_act = 0; awready = 0;
            aw_hs_cyc = cyc - 1;
        end
        if (w_hs) begin
            w_got = 1; got_wdata = p_wdata; got_wstrb = wstrb; w_act = 0; wready = 0;
            w_hs_cyc = cyc - 1;
        end
        if (b_hs) begin b_pend = 0; bvalid = 0; end
        if (aw_got && w_got) begin
            aw_got = 0; w_got = 0; b_pend = 1; b_cnt = b_dly;
            last_awsize = got_awsize; last_wstrb = got_wstrb;
            if (st_q.size() == 0) check("st_unexpected", 1, 0);
            else begin
                s = st_q.pop_front();
                check("st_addr", got_awaddr, s.addr);
                check("st_size", got_awsize, {1'b0, s.size});
                check("st_data", got_wdata, s.wdata);
                check("st_strb", got_wstrb, s.wmask);
            end
        end

        if (ifu_respValid) begin
            ifu_resp_n++; ifu_resp_cyc = cyc;
            if (ifu_q.size() == 0) check("ifu_unexpected_resp", 1, 0);
            else check("ifu_rdata", ifu_rdata, ifu_q.pop_front());
        end
        if (lsu_respValid) begin
            lsu_resp_n++; lsu_resp_cyc = cyc;
            if (lsu_q.size() == 0) check("lsu_unexpected_resp", 1, 0);
            else begin
                s = lsu_q.pop_front();
                check("lsu_rdata", lsu_rdata, s.exp_rdata);
            end
        end

        if (arvalid && !arready) begin
            if (!ar_act) begin ar_act = 1; ar_cnt = ar_dly; end
            if (ar_cnt == 0) arready = 1; else ar_cnt--;
        end
        if (rd_pend && !rvalid) begin
            if (r_cnt == 0) begin rvalid = 1; rdata = bus_word(rd_a, rd_s); rresp = rresp_val; end
            else r_cnt--;
        end
        if (awvalid && !awready) begin
            if (!aw_act) begin aw_act = 1; aw_cnt = aw_dly; end
            if (aw_cnt == 0) awready = 1; else aw_cnt--;
        end
        if (wvalid && !wready) begin
            if (!w_act) begin w_act = 1; w_cnt = w_dly; end
            if (w_cnt == 0) wready = 1; else w_cnt--;
        end
        if (b_pend && !bvalid) begin
            if (b_cnt == 0) begin bvalid = 1; bresp = bresp_val; end
            else b_cnt--;
        end

        p_arvalid = arvalid; p_araddr = araddr; p_arsize = arsize; p_rready = rready;
        p_awvalid = awvalid; p_awaddr = awaddr; p_wvalid = wvalid; p_wdata = wdata;
        p_bready = bready;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((ifu_q.size() != 0 || lsu_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        if (ifu_q.size() != 0 || lsu_q.size() != 0) check("drain_timeout", 1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, ni, nl;
        logic [1:0]  sz;
        logic [31:0] a;

        reset = 1'b1;
        clear_bench();
        #2;
        check("rst_valids", {arvalid, rready, awvalid, wvalid, bready,
                             ifu_respValid, lsu_respValid, err_valid}, 8'h00);
        check("rst_rdata", {ifu_rdata, lsu_rdata}, 64'h0);
        check("rst_addr", {araddr, awaddr}, 64'h0);
        check("rst_wfields", {wdata, wstrb, arsize, awsize}, 64'h0);
        check("rst_err_addr", err_addr, 32'h0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (2) step();

        // Zero-wait fetch: AR at cycle 2, response at cycle 4.
        fixed_en = 1'b1; fixed_val = 32'h0000_0013;
        ar_addr_log.delete(); ar_cyc_log.delete();
        c0 = cyc;
        issue_ifu(32'h8000_0000);
        step();
        drain(50);
        check("t1_resp_lat", ifu_resp_cyc - c0, 4);
        check("t1_rdata", ifu_rdata, 32'h0000_0013);
        check("t1_arsize", last_arsize, 3'd2);
        check("t1_ar_lat", (ar_cyc_log.size() > 0) ? ar_cyc_log[0] - c0 : -1, 2);
        repeat (3) step();
        check("t1_rdata_held", {ifu_respValid, ifu_rdata}, {1'b0, 32'h0000_0013});
        fixed_en = 1'b0;

        // Byte store with W delayed 3 cycles behind AW.
        w_dly = 3;
        ni = lsu_resp_n;
        c0 = cyc;
        issue_lsu(1'b1, 32'h8000_0101, 2'd0, 32'h0000_AB00, 4'b0010);
        step();
        drain(50);
        repeat (3) step();
        check("t2_aw_lat", aw_hs_cyc - c0, 2);
        check("t2_w_after_aw", w_hs_cyc - aw_hs_cyc, 3);
        check("t2_resp_lat", lsu_resp_cyc - c0, 7);
        check("t2_resp_count", lsu_resp_n - ni, 1);
        check("t2_awsize", last_awsize, 3'd0);
        check("t2_wstrb", last_wstrb, 4'b0010);
        check("t2_rdata", lsu_rdata, 32'h0);
        w_dly = 0;

        // Simultaneous pulses: LSU first, IFU right after the LSU response.
        ar_addr_log.delete(); ar_cyc_log.delete();
        issue_ifu(32'h8000_0040);
        issue_lsu(1'b0, 32'h8000_0200, 2'd2, 32'h0, 4'h0);
        step();
        drain(50);
        check("t3_ar_count", ar_addr_log.size(), 2);
        if (ar_addr_log.size() == 2) begin
            check("t3_first_ar", ar_addr_log[0], 32'h8000_0200);
            check("t3_second_ar", ar_addr_log[1], 32'h8000_0040);
            check("t3_ifu_ar_cyc", ar_cyc_log[1], lsu_resp_cyc + 1);
        end
        check("t3_order", lsu_resp_cyc < ifu_resp_cyc, 1);

        // LSU queued behind a fetch whose R channel stalls 5 cycles.
        ar_addr_log.delete(); ar_cyc_log.delete();
        ni = ifu_resp_n; nl = lsu_resp_n;
        r_dly = 5;
        c0 = cyc;
        issue_ifu(32'h8000_0080);
        repeat (3) step();
        r_dly = 0;
        issue_lsu(1'b0, 32'h8000_0300, 2'd1, 32'h0, 4'h0);
        step();
        drain(60);
        repeat (2) step();
        check("t4_ifu_lat", ifu_resp_cyc - c0, 9);
        check("t4_lsu_ar_cyc", (ar_cyc_log.size() == 2) ? ar_cyc_log[1] : -1, ifu_resp_cyc + 1);
        check("t4_resp_counts", {ifu_resp_n - ni, lsu_resp_n - nl}, {32'd1, 32'd1});

        // Randomized traffic with random slave wait states.
        for (int i = 0; i < 2500; i++) begin
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            b_dly = $urandom_range(0, 3);
            if (ifu_q.size() == 0 && $urandom_range(0, 3) == 0)
                issue_ifu($urandom() & 32'hFFFF_FFFC);
            if (lsu_q.size() == 0 && $urandom_range(0, 3) == 0) begin
                sz = 2'($urandom_range(0, 2));
                a  = $urandom() & ~((32'h1 << sz) - 32'h1);
                issue_lsu(1'($urandom_range(0, 1)), a, sz, $urandom(), 4'($urandom_range(0, 15)));
            end
            step();
        end
        drain(300);
        ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
        check("rand_stores_left", st_q.size(), 0);

        // Reset while in RDATA with an LSU request pending.
        r_dly = 20;
        issue_ifu(32'h8000_0100);
        repeat (3) step();
        issue_lsu(1'b0, 32'h8000_0400, 2'd2, 32'h0, 4'h0);
        step();
        check("t5_pre_rready", rready, 1);
        ni = ifu_resp_n; nl = lsu_resp_n;
        reset = 1'b1;
        #1;
        check("t5_async_clear", {rready, arvalid, ifu_respValid, lsu_respValid}, 4'b0000);
        clear_bench();
        r_dly = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        ar_addr_log.delete(); ar_cyc_log.delete();
        repeat (20) step();
        check("t5_no_resp", (ifu_resp_n - ni) + (lsu_resp_n - nl), 0);
        check("t5_no_ar", ar_addr_log.size(), 0);

        // Sticky error capture: only the first failing address is kept.
        check("t6_err_clear", err_valid, 0);
        rresp_val = 2'b10;
        issue_ifu(32'h1000_0000);
        step();
        drain(50);
        issue_lsu(1'b0, 32'h2000_0000, 2'd2, 32'h0, 4'h0);
        step();
        drain(50);
        rresp_val = 2'b00;
        issue_ifu(32'h3000_0000);
        step();
        drain(50);
        check("t6_err_valid", err_valid, ERR_EN);
        check("t6_err_addr", err_addr, ERR_EN ? 32'h1000_0000 : 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-to-one memory arbiter between the core's instruction-fetch port (`io_ifu_*`) and load/store port (`io_lsu_*`) and a single AXI4 subset master bus to the SoC interconnect. It latches single-cycle request pulses from either port, issues one bus transaction at a time, and returns a single-cycle response pulse with read data to the originating port. It sits directly downstream of the `cpu` block's `io_*` ports.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; only 32 is supported

Ports:
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `ifu_reqValid`  in  1  fetch request pulse
- `ifu_addr`  in  ADDR_W  fetch address, valid with pulse
- `ifu_respValid`  out  1  fetch response pulse
- `ifu_rdata`  out  DATA_W  fetched word, valid with response pulse
- `lsu_reqValid`  in  1  load/store request pulse
- `lsu_addr`  in  ADDR_W  load/store address
- `lsu_size`  in  2  log2 bytes (0=B, 1=H, 2=W)
- `lsu_wen`  in  1  1 = store
- `lsu_wdata`  in  DATA_W  store data, lane-aligned
- `lsu_wmask`  in  4  byte strobes
- `lsu_respValid`  out  1  load/store completion pulse
- `lsu_rdata`  out  DATA_W  load data (raw bus word); 0 for stores
- `arvalid`/`arready`/`araddr`/`arsize`  out/in/out/out  1/1/ADDR_W/3  read address channel
- `rvalid`/`rready`/`rdata`/`rresp`  in/out/in/in  1/1/DATA_W/2  read data channel
- `awvalid`/`awready`/`awaddr`/`awsize`  out/in/out/out  1/1/ADDR_W/3  write address channel
- `wvalid`/`wready`/`wdata`/`wstrb`  out/in/out/out  1/1/DATA_W/4  write data channel
- `bvalid`/`bready`/`bresp`  in/out/in  1/1/2  write response channel
- `err_valid`  out  1  sticky bus-error flag (see Configuration)
- `err_addr`  out  ADDR_W  address of first erroring transaction

## Operation
- Each port has a pending register (valid bit plus captured request fields). A `*_reqValid` pulse sets it, even while the bus is busy. A pulse on a port whose pending bit is already set is a protocol violation. The bench asserts on it, and the RTL ignores the second pulse.
- FSM states:
  - IDLE: if LSU is pending, grant LSU, else if IFU is pending, grant IFU. The grant clears that port's pending bit. Reads and IFU requests go to RADDR; LSU stores go to WADDR.
  - RADDR: `arvalid`=1 until `arready`, then go to RDATA.
  - RDATA: `rready`=1 until `rvalid`. Then register `rdata` and go to IDLE.
  - WADDR: `awvalid` and `wvalid` start together. Each drops independently on its own handshake. When both are done, go to WRESP.
  - WRESP: `bready`=1 until `bvalid`, then go to IDLE.
- Bus field mapping:
  - IFU: `arsize`=3'd2.
  - LSU: `arsize`/`awsize` = {1'b0, `lsu_size`}, `wstrb`=`lsu_wmask`, `wdata`=`lsu_wdata`.
  - Addresses pass through unmodified.
- A request pulse that arrives in the same cycle the FSM is in IDLE is captured into pending first and granted in the following cycle.
- Simultaneous IFU and LSU pulses: LSU is served first, and IFU stays pending.
- Responses: the granted port's `*_respValid` pulses for one cycle, the cycle after the R or B handshake. `*_rdata` is held until the next response to that port.
- Responses are returned regardless of `rresp`/`bresp`.

## Timing
- Reset values: all `*valid`/`*ready` outputs 0, both `*_respValid` 0, both `*_rdata` 0, `araddr`/`awaddr`/`wdata`/`wstrb`/sizes 0, `err_valid` 0, `err_addr` 0, FSM in IDLE, pending bits cleared.
- Read with zero-wait slave: pulse at cycle 0, `arvalid` at cycle 2, `rready` at cycle 3, `respValid` at cycle 4.
- Write with zero-wait slave: pulse at cycle 0, `awvalid`/`wvalid` at cycle 2, `bready` at cycle 3, `respValid` at cycle 4.
- Each wait cycle on `*ready` or `rvalid`/`bvalid` adds exactly one cycle.
- Bus outputs are registered, and valid signals never drop before their handshake.
- Reset asserted mid-transaction: all outputs take reset values immediately and asynchronously. The in-flight and pending requests are discarded, with no response.

## Configuration
- `MEM_ARB_ERR_EN` defined: on the first `rresp`≠0 or `bresp`≠0, set `err_valid`=1 and capture that transaction's address into `err_addr`. Both hold until reset, and later errors do not overwrite them.
- `MEM_ARB_ERR_EN` undefined: `err_valid` and `err_addr` are tied to 0.

## Test plan
- IFU read of 0x8000_0000, slave `arready`=1 and `rvalid`=1 at the first opportunity, `rdata`=0x0000_0013 -> `ifu_respValid` pulses at cycle 4 with `ifu_rdata`=0x0000_0013, `arsize`=2.
- LSU store SB to 0x8000_0101 with `wdata`=0x0000_AB00 and `wmask`=4'b0010; `wready` is delayed 3 cycles after `awready` -> `awvalid` drops first, `wvalid` is held 3 cycles, then `lsu_respValid` pulses once; `awsize`=0 and `wstrb`=4'b0010.
- IFU and LSU load pulses in the same cycle -> LSU AR is issued first, IFU AR follows after `lsu_respValid`, and each response goes only to its own port.
- LSU pulse while an IFU read is stalled (`rvalid` held low 5 cycles) -> LSU is queued and issued the cycle after `ifu_respValid`, with no lost or duplicated response.
- `reset` asserted while in RDATA -> `rready` and `arvalid` go to 0 in the same cycle, and no `respValid` pulses after reset is released.
- With `MEM_ARB_ERR_EN`: `rresp`=2 on a read of 0x1000_0000, followed by a second error at 0x2000_0000 -> `err_valid`=1 and `err_addr`=0x1000_0000 both persist. Without the macro, `err_valid` stays 0.
